program_sequencer: RTL and testbench
====================================

# program_sequencer

Instruction-stream sequencer sitting between program memory and the processor core (control unit plus datapath). Owns the program counter, fetches each 9-bit instruction word and, for `mvi`, its immediate word from a synchronous memory port, presents them on `DIN`, pulses `Run` and waits for `Done`. Supports free-run, single-step, halt at instruction boundary, and a stuck-instruction watchdog.

## Interface
- `ADDR_W`, default 7: program memory address width; PC width.
- `DATA_W`, default 16: memory and `DIN` width; the instruction occupies `[8:0]`.
- `MEM_LAT`, default 1: read latency in cycles, ≥1.
- `TIMEOUT`, default 15: maximum EXEC cycles without `Done` before fault, ≥2.

Ports:
- `Clock` in 1: rising-edge clock.
- `Resetn` in 1: reset, synchronous, active-low.
- `Go` in 1: level; start or continue free-run from IDLE.
- `Step` in 1: level; execute exactly one instruction from IDLE.
- `Halt` in 1: level; stop at the next instruction boundary.
- `PcLoad` in 1: in IDLE only, PC ← `PcIn`.
- `PcIn` in ADDR_W: PC load value.
- `MemRd` out 1: read strobe.
- `MemAddr` out ADDR_W: read address.
- `MemData` in DATA_W: read data, valid `MEM_LAT` cycles after the `MemRd` cycle.
- `DIN` out DATA_W: processor data input.
- `Run` out 1: one-cycle start pulse to the control unit.
- `Done` in 1: instruction complete, from the control unit.
- `Busy` out 1: high in every state except IDLE and FAULT.
- `Fault` out 1: watchdog tripped; sticky.
- `Pc` out ADDR_W: current PC.

## Operation
- States: IDLE, FETCH, WAIT, FETCH_IMM, WAIT_IMM, ISSUE, EXEC, FAULT.
- IDLE:
  - `PcLoad` has priority over everything else.
  - Otherwise `Halt` keeps the block in IDLE.
  - Otherwise `Go` sets `free` and moves to FETCH. `Go` beats `Step` when both are high.
  - Otherwise `Step` clears `free` and moves to FETCH.
- FETCH (1 cycle): `MemRd`=1, `MemAddr`=PC, PC←PC+1 (mod 2^ADDR_W); then WAIT.
- WAIT (`MEM_LAT` cycles): on the last cycle, latch `MemData` into `instr`.
  - If `instr[8:6]`==3'b001 (mvi), go to FETCH_IMM.
  - Otherwise go to ISSUE.
- FETCH_IMM / WAIT_IMM: same as FETCH / WAIT, latching into `imm`; then ISSUE.
- ISSUE (1 cycle): `Run`=1, `DIN`=`instr`, watchdog counter cleared; then EXEC.
- EXEC:
  - `DIN`=`imm` if the instruction is mvi, else `instr`. `Run`=0.
  - `Done`=1 → boundary check:
    - If `Halt` or not `free`, go to IDLE.
    - Otherwise go to FETCH.
  - The counter reaches `TIMEOUT` without `Done` → FAULT.
- FAULT: `Fault`=1 and `Busy`=0; the block leaves FAULT only on reset. `Go`, `Step` and `PcLoad` are ignored.
- `Halt` during a non-IDLE state never aborts an instruction; it is sampled only at the `Done` boundary and in IDLE.
- `Done` outside EXEC is ignored.
- `MemRd`=0 in every state except FETCH and FETCH_IMM.

## Timing
- Reset (`Resetn`=0 at a rising edge, in any state including mid-instruction):
  - State=IDLE; `Pc`=0, `MemAddr`=0, `MemRd`=0, `DIN`=0, `Run`=0, `Busy`=0, `Fault`=0; `instr`=`imm`=0; `free`=0.
- `Run` is high for exactly one cycle per instruction and is always preceded by at least one low cycle, so the control unit sees a rising edge.
- Cycles from FETCH entry to the `Run` cycle:
  - Non-mvi: 1+`MEM_LAT`.
  - mvi: 2+2·`MEM_LAT`.
- EXEC lasts at least 1 cycle. In free-run, FETCH of the next instruction starts the cycle after `Done` is sampled.
- `DIN` changes only on entry to ISSUE and on entry to EXEC; it holds otherwise, including in IDLE after completion.
- PC wraps from 2^ADDR_W−1 to 0 with no flag. An mvi at address 2^ADDR_W−1 fetches its immediate from address 0.

## Structure
- A shared package holds:
  - The state enum.
  - The opcode constants: MV=3'b000, MVI=3'b001, SUB=3'b011, MVNZ=3'b100.
  - The instruction field slice positions (opcode `[8:6]`, Rx `[5:3]`, Ry `[2:0]`).
- One sub-module, `pc_counter`:
  - Inputs: load, increment, synchronous active-low reset.
  - Output: width ADDR_W.
- The watchdog and memory-latency counters are inline.

## Test plan
- Reset mid-EXEC with `Busy`=1: after the edge, all outputs hold their reset values and the next `Go` fetches address 0.
- Single-step a `mv` (MemData=9'b000_001_010), `MEM_LAT`=1, `Done` returned 1 cycle after `Run`:
  - `Run` occurs 2 cycles after FETCH entry with `DIN`=0x00A.
  - Afterwards: IDLE, `Pc`=1, `Busy`=0.
- `mvi` at address 5 (mem[5]=9'b001_011_000, mem[6]=0x1234):
  - Two `MemRd` pulses, at addresses 5 then 6.
  - `DIN`=0x0058 in the `Run` cycle, then 0x1234 during EXEC.
  - Final `Pc`=7.
- Free-run three instructions with `Halt` raised during the second EXEC: the second completes, the third is never fetched, and the block returns to IDLE with `Pc`=2.
- `Done` is never returned, `TIMEOUT`=15: `Fault` rises 15 cycles after `Run`; it then stays high and `Go` has no effect until `Resetn`=0.
- `PcLoad` with `PcIn`=127 (`ADDR_W`=7) then `Go`, program is mvi:
  - Addresses 127 then 0 are fetched; `Pc`=1 after ISSUE.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared state encoding and instruction-format constants for the program sequencer
// and its PC counter.
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StFetchImm,
        StWaitImm,
        StIssue,
        StExec,
        StFault
    } state_e;

    localparam int unsigned InstrW = 9;

    localparam logic [2:0] OpMv   = 3'b000;
    localparam logic [2:0] OpMvi  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpMvnz = 3'b100;

    localparam int unsigned OpMsb = 8;
    localparam int unsigned OpLsb = 6;
    localparam int unsigned RxMsb = 5;
    localparam int unsigned RxLsb = 3;
    localparam int unsigned RyMsb = 2;
    localparam int unsigned RyLsb = 0;

    function automatic logic is_mvi(input logic [InstrW-1:0] instr);
        return instr[OpMsb:OpLsb] == OpMvi;
    endfunction

endpackage

// File: rtl/program_sequencer_pc_counter.sv
// Program counter: synchronous active-low reset, parallel load, and a wrapping increment.
module pc_counter
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Instruction-stream sequencer: fetches instruction (and mvi immediate) words, drives DIN,
// pulses Run and waits for Done, with step/free-run/halt control and a watchdog.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Go,
    input  logic              Step,
    input  logic              Halt,
    input  logic              PcLoad,
    input  logic [ADDR_W-1:0] PcIn,
    output logic              MemRd,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Fault,
    output logic [ADDR_W-1:0] Pc
);

    localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(MEM_LAT - 1);
    localparam int unsigned WdW = $clog2(TIMEOUT);
    // Trip on the last EXEC cycle so Fault rises TIMEOUT cycles after the Run cycle.
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 2);

    state_e             state_q;
    logic               free_q;
    logic [InstrW-1:0]  instr_q;
    logic [DATA_W-1:0]  imm_q;
    logic [LatW-1:0]    lat_q;
    logic [WdW-1:0]     wd_q;
    logic               pc_load;
    logic               pc_inc;

    assign pc_load = (state_q == StIdle) && PcLoad;
    assign pc_inc  = (state_q == StFetch) || (state_q == StFetchImm);

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (PcIn),
        .count    (Pc)
    );

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= StIdle;
            free_q  <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
            lat_q   <= '0;
            wd_q    <= '0;
            MemRd   <= 1'b0;
            MemAddr <= '0;
            DIN     <= '0;
            Run     <= 1'b0;
            Busy    <= 1'b0;
            Fault   <= 1'b0;
        end else begin
            MemRd <= 1'b0;
            Run   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!PcLoad && !Halt && (Go || Step)) begin
                        free_q  <= Go;
                        state_q <= StFetch;
                        MemRd   <= 1'b1;
                        MemAddr <= Pc;
                        Busy    <= 1'b1;
                    end
                end
                StFetch: begin
                    state_q <= StWait;
                    lat_q   <= '0;
                end
                StWait: begin
                    if (lat_q == LatLast) begin
                        instr_q <= MemData[InstrW-1:0];
                        if (is_mvi(MemData[InstrW-1:0])) begin
                            // PC already points past the opcode word.
                            state_q <= StFetchImm;
                            MemRd   <= 1'b1;
                            MemAddr <= Pc;
                        end else begin
                            state_q <= StIssue;
                            Run     <= 1'b1;
                            DIN     <= DATA_W'(MemData[InstrW-1:0]);
                        end
                    end else begin
                        lat_q <= lat_q + LatW'(1);
                    end
                end
                StFetchImm: begin
                    state_q <= StWaitImm;
                    lat_q   <= '0;
                end
                StWaitImm: begin
                    if (lat_q == LatLast) begin
                        imm_q   <= MemData;
                        state_q <= StIssue;
                        Run     <= 1'b1;
                        DIN     <= DATA_W'(instr_q);
                    end else begin
                        lat_q <= lat_q + LatW'(1);
                    end
                end
                StIssue: begin
                    state_q <= StExec;
                    wd_q    <= '0;
                    DIN     <= is_mvi(instr_q) ? imm_q : DATA_W'(instr_q);
                end
                StExec: begin
                    if (Done) begin
                        if (Halt || !free_q) begin
                            state_q <= StIdle;
                            Busy    <= 1'b0;
                        end else begin
                            state_q <= StFetch;
                            MemRd   <= 1'b1;
                            MemAddr <= Pc;
                        end
                    end else if (wd_q == WdLast) begin
                        state_q <= StFault;
                        Fault   <= 1'b1;
                        Busy    <= 1'b0;
                    end else begin
                        wd_q <= wd_q + WdW'(1);
                    end
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: an ISA-level model queues expected fetches and Run/DIN values; a monitor
// pops and compares them whenever the sequencer strobes MemRd or Run.
module tb_program_sequencer;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;
    localparam int unsigned MemLat = 1;
    localparam int unsigned Timeout = 15;

    typedef struct {
        logic [AW-1:0] addr;
        logic          first;
    } fetch_t;

    typedef struct {
        logic [DW-1:0] din_issue;
        logic [DW-1:0] din_exec;
        int            lat;
    } run_t;

    logic clk = 1'b0;
    logic Resetn, Go, Step, Halt, PcLoad, Done;
    logic halt_tb, halt_cu, cu_mute;
    logic [AW-1:0] PcIn;
    logic MemRd, Run, Busy, Fault;
    logic [AW-1:0] MemAddr, Pc;
    logic [DW-1:0] MemData, DIN;

    logic [DW-1:0] mem [128];
    fetch_t exp_fetch[$];
    run_t   exp_run[$];
    logic [AW-1:0] m_pc;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fetch_cyc = 0;
    int last_run_cyc = 0;
    int runs_seen = 0;
    int halt_at = 0;
    int done_cnt = 0;
    logic exp_exec = 1'b0;
    logic [DW-1:0] exec_val;

    assign Halt = halt_tb | halt_cu;

    always #5 clk = ~clk;

    program_sequencer #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (MemLat),
        .TIMEOUT (Timeout)
    ) dut (
        .Clock   (clk),
        .Resetn  (Resetn),
        .Go      (Go),
        .Step    (Step),
        .Halt    (Halt),
        .PcLoad  (PcLoad),
        .PcIn    (PcIn),
        .MemRd   (MemRd),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .DIN     (DIN),
        .Run     (Run),
        .Done    (Done),
        .Busy    (Busy),
        .Fault   (Fault),
        .Pc      (Pc)
    );

    // Synchronous program memory, one cycle of read latency.
    always @(posedge clk) if (MemRd) MemData <= mem[MemAddr];

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ISA-level model: each instruction is one fetch, plus the following word for mvi.
    task automatic model_run(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            logic [AW-1:0] nxt;
            fetch_t f;
            run_t r;
            w = mem[m_pc];
            nxt = m_pc + 7'd1;
            f.addr = m_pc;
            f.first = 1'b1;
            exp_fetch.push_back(f);
            r.din_issue = {7'b0, w[8:0]};
            if (w[8:6] == 3'b001) begin
                f.addr = nxt;
                f.first = 1'b0;
                exp_fetch.push_back(f);
                r.din_exec = mem[nxt];
                r.lat = 2 + 2 * MemLat;
                m_pc = nxt + 7'd1;
            end else begin
                r.din_exec = r.din_issue;
                r.lat = 1 + MemLat;
                m_pc = nxt;
            end
            exp_run.push_back(r);
        end
    endtask

    // Monitor: compares every fetch and every Run against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        if (exp_exec) begin
            check("din_exec", DIN, exec_val);
            exp_exec = 1'b0;
        end
        if (MemRd) begin
            if (exp_fetch.size() == 0) begin
                check("unexpected_fetch", MemRd, 1'b0);
            end else begin
                fetch_t f;
                f = exp_fetch.pop_front();
                check("fetch_addr", MemAddr, f.addr);
                if (f.first) fetch_cyc = cyc;
            end
        end
        if (Run) begin
            last_run_cyc = cyc;
            if (exp_run.size() == 0) begin
                check("unexpected_run", Run, 1'b0);
            end else begin
                run_t r;
                r = exp_run.pop_front();
                check("din_issue", DIN, r.din_issue);
                check("fetch_to_run", cyc - fetch_cyc, r.lat);
                exec_val = r.din_exec;
                exp_exec = 1'b1;
            end
        end
    end

    // Control-unit model: Done 1..4 cycles after Run; raises Halt on the chosen Run.
    initial begin
        Done = 1'b0;
        halt_cu = 1'b0;
        forever begin
            @(negedge clk);
            Done = 1'b0;
            if (!Busy) halt_cu = 1'b0;
            if (done_cnt != 0) begin
                done_cnt--;
                if (done_cnt == 0) Done = 1'b1;
            end
            if (Run && !cu_mute) begin
                done_cnt = $urandom_range(4, 1);
                runs_seen++;
                if (runs_seen == halt_at) halt_cu = 1'b1;
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, Busy, 1'b0);
    endtask

    task automatic launch(input logic go, input logic step, input int k);
        halt_at = go ? runs_seen + k : 0;
        Go = go;
        Step = step;
        @(negedge clk);
        Go = 1'b0;
        Step = 1'b0;
        wait_idle("return_idle");
    endtask

    task automatic load_pc(input logic [AW-1:0] a);
        PcLoad = 1'b1;
        PcIn = a;
        @(negedge clk);
        PcLoad = 1'b0;
        m_pc = a;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, Pc, '0);
        check({tag, "_memaddr"}, MemAddr, '0);
        check({tag, "_memrd"}, MemRd, 1'b0);
        check({tag, "_din"}, DIN, '0);
        check({tag, "_run"}, Run, 1'b0);
        check({tag, "_busy"}, Busy, 1'b0);
        check({tag, "_fault"}, Fault, 1'b0);
    endtask

    initial begin
        logic [2:0] ops [4];
        int n;
        ops[0] = 3'b000;
        ops[1] = 3'b001;
        ops[2] = 3'b011;
        ops[3] = 3'b100;
        Resetn = 1'b0;
        Go = 1'b0;
        Step = 1'b0;
        halt_tb = 1'b0;
        PcLoad = 1'b0;
        PcIn = '0;
        cu_mute = 1'b0;
        m_pc = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        Resetn = 1'b1;

        // Single-step a mv.
        mem[0] = 16'h000A;
        model_run(1);
        launch(1'b0, 1'b1, 0);
        check("step_mv_pc", Pc, 7'd1);
        check("step_mv_din_hold", DIN, 16'h000A);

        // Single-step an mvi at address 5.
        mem[5] = 16'h0058;
        mem[6] = 16'h1234;
        load_pc(7'd5);
        model_run(1);
        launch(1'b0, 1'b1, 0);
        check("mvi_pc", Pc, 7'd7);
        check("mvi_din_hold", DIN, 16'h1234);

        // Reset in the middle of EXEC, then free-run from 0 with Halt during the second EXEC.
        mem[3] = 16'h00C1;
        load_pc(7'd3);
        cu_mute = 1'b1;
        model_run(1);
        Step = 1'b1;
        @(negedge clk);
        Step = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_exec", Busy, 1'b1);
        Resetn = 1'b0;
        @(negedge clk);
        check_reset("reset_mid_exec");
        Resetn = 1'b1;
        cu_mute = 1'b0;
        m_pc = '0;
        mem[0] = 16'h000A;
        mem[1] = 16'h00C1;
        mem[2] = 16'h0100;
        model_run(2);
        launch(1'b1, 1'b0, 2);
        check("halt_pc", Pc, 7'd2);

        // mvi at the top address takes its immediate from address 0.
        mem[127] = 16'h0079;
        mem[0] = 16'hBEEF;
        load_pc(7'd127);
        model_run(1);
        launch(1'b1, 1'b0, 1);
        check("wrap_pc", Pc, 7'd1);
        check("wrap_din", DIN, 16'hBEEF);

        // Halt held in IDLE blocks Go.
        halt_at = runs_seen + 1;
        model_run(1);
        halt_tb = 1'b1;
        Go = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_idle_busy", Busy, 1'b0);
        check("halt_idle_pc", Pc, 7'd1);
        halt_tb = 1'b0;
        @(negedge clk);
        Go = 1'b0;
        wait_idle("halt_release_idle");
        check("halt_release_pc", Pc, m_pc);

        // Randomized programs, entry points and run modes.
        for (int r = 0; r < 30; r++) begin
            int mode;
            int k;
            if (r % 10 == 0) begin
                for (int i = 0; i < 128; i++) begin
                    mem[i] = {7'b0, ops[$urandom_range(3, 0)], 6'($urandom)};
                end
            end
            if ($urandom_range(1, 0) == 1) begin
                // Go alongside PcLoad must not start a fetch.
                Go = 1'($urandom_range(1, 0));
                load_pc(7'($urandom));
                Go = 1'b0;
            end
            mode = $urandom_range(2, 0);
            k = $urandom_range(4, 1);
            model_run(mode == 0 ? 1 : k);
            launch(mode != 0, mode != 1, k);
            check("round_pc", Pc, m_pc);
        end

        // Watchdog: no Done ever returned.
        cu_mute = 1'b1;
        model_run(1);
        Step = 1'b1;
        @(negedge clk);
        Step = 1'b0;
        n = 0;
        while (!Fault && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("fault_latency", cyc - last_run_cyc, Timeout);
        check("fault_busy", Busy, 1'b0);
        Go = 1'b1;
        repeat (5) @(negedge clk);
        check("fault_sticky", Fault, 1'b1);
        check("fault_go_ignored", Busy, 1'b0);
        Go = 1'b0;
        Resetn = 1'b0;
        @(negedge clk);
        check_reset("reset_after_fault");
        Resetn = 1'b1;
        cu_mute = 1'b0;

        check("fetch_queue_empty", exp_fetch.size(), 0);
        check("run_queue_empty", exp_run.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
